// File: rtl/oh2b_pkg.sv
// Shared definitions for the one-hot/positional to binary stream encoder.
// Holds the default widths, the derived positional width and the
// operation codes used by the saturating error counter.
package oh2b_pkg;

    // Default width of the binary index.
    localparam int N_DEFAULT  = 3;

    // Default width of the illegal-word counter.
    localparam int CW_DEFAULT = 8;

    // Width of the positional word that carries an N-bit index.
    function automatic int pos_width(input int n);
        return 2 ** n;
    endfunction

    localparam int PW_DEFAULT = pos_width(N_DEFAULT);

    // Saturation point of the default-width error counter.
    localparam logic [CW_DEFAULT-1:0] ERR_CNT_MAX = '1;

    // Next-state selection for the error counter, one per clock.
    typedef enum logic [1:0] {
        CNT_HOLD     = 2'd0,
        CNT_INC      = 2'd1,
        CNT_CLEAR    = 2'd2,
        CNT_LOAD_ONE = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/oh2b_core.sv
// Combinational positional-to-binary encoder.
// binary is the index of the lowest set bit (0 when no bit is set);
// onehot_ok is high only when exactly one bit of the word is set.
module oh2b_core
    import oh2b_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [pos_width(N)-1:0] positional,
    output logic [N-1:0]            binary,
    output logic                    onehot_ok
);

    localparam int PW = pos_width(N);

    // Lowest-set-bit priority encoder: scanning downward lets the lowest hit win.
    always_comb begin
        // NOTE: default assignment first so no path leaves binary unassigned (no latch).
        binary = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (positional[i]) begin
                binary = N'(i);
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign onehot_ok = (positional != '0) &&
                       ((positional & (positional - PW'(1))) == '0);

endmodule

// File: rtl/oh2b_stream.sv
// Valid/ready stream wrapper around oh2b_core.
// One registered output stage with full throughput and backpressure,
// a per-word legality flag and a saturating count of accepted illegal words.
module oh2b_stream
    import oh2b_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [pos_width(N)-1:0] positional,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N-1:0]            binary,
    output logic                    err,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic [CW-1:0]           err_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [N-1:0] enc_binary;
    logic         enc_ok;
    logic         accept;
    logic         illegal_acc;
    cnt_op_e      cnt_op;

    oh2b_core #(
        .N (N)
    ) u_core (
        .positional (positional),
        .binary     (enc_binary),
        .onehot_ok  (enc_ok)
    );

    // The stage can take a word when it is empty or its word leaves this cycle.
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign illegal_acc = accept && !enc_ok;

    // Output register: load on accept, drop valid on a drain without reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments in clocked blocks so every register
            // samples pre-edge values regardless of statement order.
            out_valid <= 1'b0;
            binary    <= '0;
            err       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            binary    <= enc_binary;
            err       <= !enc_ok;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Select the counter operation; clear has priority over increment.
    always_comb begin
        cnt_op = CNT_HOLD;
        if (err_clr) begin
            cnt_op = illegal_acc ? CNT_LOAD_ONE : CNT_CLEAR;
        end else if (illegal_acc && (err_cnt != CNT_MAX)) begin
            cnt_op = CNT_INC;
        end
    end

    // Saturating illegal-word counter; only accepted words are counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else begin
            case (cnt_op)
                CNT_INC:      err_cnt <= err_cnt + CW'(1);
                CNT_CLEAR:    err_cnt <= '0;
                CNT_LOAD_ONE: err_cnt <= CW'(1);
                default:      err_cnt <= err_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_oh2b_stream.sv
// Directed bench for oh2b_stream: a reference encoder and counter model,
// with expected output words queued on accept and compared while held.
module tb_oh2b_stream;

    localparam int N  = 3;
    localparam int CW = 8;
    localparam int PW = 8;

    typedef struct packed {
        logic [N-1:0] b;
        logic         e;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] positional;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  binary;
    logic          err;
    logic          out_valid;
    logic          out_ready;
    logic          err_clr;
    logic [CW-1:0] err_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    int   m_cnt = 0;

    oh2b_stream #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .positional (positional),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .binary     (binary),
        .err        (err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_clr    (err_clr),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Reference encoding: lowest set bit, illegal unless exactly one bit set.
    function automatic exp_t ref_enc(input logic [PW-1:0] p);
        exp_t r;
        r.b = '0;
        for (int i = 0; i < PW; i++) begin
            if (p[i]) begin
                r.b = N'(i);
                break;
            end
        end
        r.e = ($countones(p) != 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance models, check outputs.
    task automatic step(input logic [PW-1:0] pos, input logic vld, input logic ordy,
                        input logic clr, input logic rst);
        logic m_ready;
        logic acc;
        exp_t w;
        int   nxt_cnt;
        positional = pos;
        in_valid   = vld;
        out_ready  = ordy;
        err_clr    = clr;
        rst_n      = !rst;
        #1;
        m_ready = (sb_q.size() == 0) || ordy;
        check("in_ready", in_ready, m_ready);
        acc = vld && m_ready && !rst;
        w   = ref_enc(pos);
        nxt_cnt = m_cnt;
        if (clr) nxt_cnt = (acc && w.e) ? 1 : 0;
        else if (acc && w.e && m_cnt != 255) nxt_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
        if (rst) begin
            sb_q.delete();
            m_cnt = 0;
            check("rst_binary", binary, 0);
            check("rst_err", err, 0);
        end else begin
            if (sb_q.size() != 0 && ordy) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(w);
            m_cnt = nxt_cnt;
        end
        check("out_valid", out_valid, sb_q.size() != 0);
        if (sb_q.size() != 0) begin
            check("binary", binary, sb_q[0].b);
            check("err", err, sb_q[0].e);
        end
        check("err_cnt", err_cnt, m_cnt);
    endtask

    initial begin
        logic [PW-1:0] p;
        positional = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        err_clr    = 1'b0;
        rst_n      = 1'b0;

        // Reset state.
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_cnt", err_cnt, 0);

        // Walking one at full throughput, with a decode loopback.
        for (int k = 0; k < PW; k++) begin
            p = 8'b1 << k;
            step(p, 1'b1, 1'b1, 1'b0, 1'b0);
            check("walk_bin", binary, k);
            check("loopback", 8'b1 << binary, p);
        end

        // Illegal words: zero, multi-bit, all ones.
        step(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        step(8'h2C, 1'b1, 1'b1, 1'b0, 1'b0);
        check("multi_bin", binary, 2);
        step(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        check("cnt_three", err_cnt, 3);

        // Idle cycles with junk on positional must not disturb any state.
        for (int k = 0; k < 3; k++) step(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);

        // Stall: hold 00010000 while 01000000 waits, then release.
        step(8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stall_bin", binary, 4);
        step(8'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        check("release_bin", binary, 6);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Saturation: clear, 255 illegal words, one more, then clear with an illegal word.
        step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 255; k++) begin
            step((k % 2 == 0) ? 8'h00 : 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        check("cnt_full", err_cnt, 255);
        step(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        check("cnt_sat", err_cnt, 255);
        step(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_plus_one", err_cnt, 1);

        // Reset in the middle of a held word with a new word offered.
        step(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        step(8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_valid", out_valid, 0);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
